mem_port_arbiter: RTL and testbench

- Shares one Avalon-style 32-bit memory slave between the CPU instruction-fetch port and data port.
- The slave has a single address/read/write/writedata/byteenable/readdata/waitrequest interface and returns readdata one cycle after an accepted read.
- The block serialises requests, holds the bus under waitrequest, captures read data and returns per-port completion pulses.
- Sits between the CPU core and the unified memory in the test harness and the top level.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU fetch/data request ports and the shared Avalon-style memory bus.
// The arbiter is the bus master; the CPU and memory side are seen through the slave view.
interface mem_port_arbiter_if;
  logic [31:0] i_address;
  logic        i_read;
  logic [31:0] i_readdata;
  logic        i_done;

  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_done;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport master (
    input  i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
    input  mem_readdata, mem_waitrequest,
    output i_readdata, i_done, d_readdata, d_done,
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
  );

  modport slave (
    output i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
    output mem_readdata, mem_waitrequest,
    input  i_readdata, i_done, d_readdata, d_done,
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and data accesses onto one memory slave; every output is registered
// and a completion pulse with captured read data is returned to the owning port.
module mem_port_arbiter #(
  parameter int DATA_PRIORITY = 0,
  parameter int READ_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  mem_port_arbiter_if.master         bus,
  output logic                       busy,
  output logic                       grant_data
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_data_q, grant_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;

  logic i_elig, d_elig, pick_data;

  // A port whose done pulse is showing is not eligible, so a requester may drop late.
  assign i_elig = bus.i_read & ~i_done_q;
  assign d_elig = (bus.d_read | bus.d_write) & ~d_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      grant_data_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      last_grant_q <= last_grant_d;
      grant_data_q <= grant_data_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    last_grant_d = last_grant_q;
    grant_data_d = grant_data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    if (d_elig && !i_elig)      pick_data = 1'b1;
    else if (i_elig && !d_elig) pick_data = 1'b0;
    else if (DATA_PRIORITY != 0) pick_data = 1'b1;
    else                         pick_data = ~last_grant_q;

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          grant_data_d = pick_data;
          last_grant_d = pick_data;
          state_d      = BUS;
          if (pick_data) begin
            addr_d  = bus.d_address;
            wdata_d = bus.d_writedata;
            be_d    = bus.d_byteenable;
            wr_d    = bus.d_write;
            rd_d    = ~bus.d_write;
          end else begin
            addr_d  = bus.i_address;
            be_d    = 4'hF;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
        end
      end
      BUS: begin
        if (!bus.mem_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_q) begin
            d_done_d = 1'b1;
            state_d  = IDLE;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else begin
          state_d = IDLE;
          if (grant_data_q) begin
            d_rdata_d = bus.mem_readdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = bus.mem_readdata;
            i_done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_address    = addr_q;
    bus.mem_read       = rd_q;
    bus.mem_write      = wr_q;
    bus.mem_writedata  = wdata_q;
    bus.mem_byteenable = be_q;
    bus.i_readdata     = i_rdata_q;
    bus.i_done         = i_done_q;
    bus.d_readdata     = d_rdata_q;
    bus.d_done         = d_done_q;
    busy               = (state_q != IDLE);
    grant_data         = grant_data_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance A with a small memory model,
// data-priority instance B with an address-derived read model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic busy_a, gd_a, busy_b, gd_b;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem_a [0:15];

  mem_port_arbiter_if ifa();
  mem_port_arbiter_if ifb();

  mem_port_arbiter #(.DATA_PRIORITY(0), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.master), .busy(busy_a), .grant_data(gd_a));
  mem_port_arbiter #(.DATA_PRIORITY(1), .READ_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.master), .busy(busy_b), .grant_data(gd_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory A: low 64 bytes are RAM, BFC00000 holds a boot word, elsewhere addr^A5A50000.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) mem_a[k] <= '0;
      ifa.mem_readdata <= '0;
    end else begin
      if (ifa.mem_read && !ifa.mem_waitrequest)
        ifa.mem_readdata <= (ifa.mem_address[31:6] == 26'd0) ? mem_a[ifa.mem_address[5:2]] :
                            (ifa.mem_address == 32'hBFC0_0000) ? 32'h3C08_0001 :
                            (ifa.mem_address ^ 32'hA5A5_0000);
      if (ifa.mem_write && !ifa.mem_waitrequest)
        mem_a[ifa.mem_address[5:2]] <= merge(mem_a[ifa.mem_address[5:2]],
                                             ifa.mem_writedata, ifa.mem_byteenable);
    end
  end

  always @(posedge clk)
    if (ifb.mem_read && !ifb.mem_waitrequest) ifb.mem_readdata <= ifb.mem_address ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.i_address = '0; ifa.i_read = 1'b0; ifa.d_address = '0; ifa.d_read = 1'b0;
    ifa.d_write = 1'b0; ifa.d_writedata = '0; ifa.d_byteenable = '0; ifa.mem_waitrequest = 1'b0;
    ifb.i_address = '0; ifb.i_read = 1'b0; ifb.d_address = '0; ifb.d_read = 1'b0;
    ifb.d_write = 1'b0; ifb.d_writedata = '0; ifb.d_byteenable = '0; ifb.mem_waitrequest = 1'b0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_grant", gd_a, 1'b0);
    chk1("rst_mem_read", ifa.mem_read, 1'b0);
    chk1("rst_mem_write", ifa.mem_write, 1'b0);
    chk32("rst_mem_addr", ifa.mem_address, 32'h0);
    chk1("rst_i_done", ifa.i_done, 1'b0);
    chk1("rst_d_done", ifa.d_done, 1'b0);
    chk32("rst_i_rdata", ifa.i_readdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single fetch, no wait states
    ifa.i_read = 1'b1; ifa.i_address = 32'hBFC0_0000;
    tick();
    chk1("f_c1_read", ifa.mem_read, 1'b1);
    chk32("f_c1_addr", ifa.mem_address, 32'hBFC0_0000);
    chk32("f_c1_be", {28'd0, ifa.mem_byteenable}, 32'hF);
    chk1("f_c1_busy", busy_a, 1'b1);
    chk1("f_c1_grant", gd_a, 1'b0);
    chk1("f_c1_done", ifa.i_done, 1'b0);
    tick();
    chk1("f_c2_read", ifa.mem_read, 1'b0);
    chk1("f_c2_done", ifa.i_done, 1'b0);
    tick();
    chk1("f_c3_done", ifa.i_done, 1'b1);
    chk32("f_c3_data", ifa.i_readdata, 32'h3C08_0001);
    ifa.i_read = 1'b0;
    tick();
    chk1("f_c4_done", ifa.i_done, 1'b0);
    chk1("f_c4_busy", busy_a, 1'b0);
    chk1("f_c4_read", ifa.mem_read, 1'b0);
    chk32("f_c4_data_hold", ifa.i_readdata, 32'h3C08_0001);

    // Write held off by two wait-state cycles
    ifa.d_write = 1'b1; ifa.d_address = 32'h10; ifa.d_writedata = 32'hDEAD_BEEF;
    ifa.d_byteenable = 4'b0011; ifa.mem_waitrequest = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk1("w_write", ifa.mem_write, 1'b1);
      chk32("w_addr", ifa.mem_address, 32'h10);
      chk32("w_wdata", ifa.mem_writedata, 32'hDEAD_BEEF);
      chk32("w_be", {28'd0, ifa.mem_byteenable}, 32'h3);
      chk1("w_grant", gd_a, 1'b1);
      chk1("w_d_done_early", ifa.d_done, 1'b0);
      chk1("w_i_done", ifa.i_done, 1'b0);
    end
    ifa.mem_waitrequest = 1'b0;
    tick();
    chk1("w_done", ifa.d_done, 1'b1);
    chk1("w_write_drop", ifa.mem_write, 1'b0);
    chk1("w_i_done2", ifa.i_done, 1'b0);
    ifa.d_write = 1'b0;
    tick();
    chk1("w_done_once", ifa.d_done, 1'b0);
    chk1("w_idle", busy_a, 1'b0);

    // Read and write together: write wins
    ifa.d_read = 1'b1; ifa.d_write = 1'b1; ifa.d_address = 32'h20;
    ifa.d_writedata = 32'h1234_5678; ifa.d_byteenable = 4'hF;
    tick();
    chk1("rw_write", ifa.mem_write, 1'b1);
    chk1("rw_noread", ifa.mem_read, 1'b0);
    tick();
    chk1("rw_done", ifa.d_done, 1'b1);
    chk1("rw_noread2", ifa.mem_read, 1'b0);
    ifa.d_read = 1'b0; ifa.d_write = 1'b0;
    tick();
    chk1("rw_done_once", ifa.d_done, 1'b0);
    chk1("rw_noread3", ifa.mem_read, 1'b0);

    // Data read-back of the partial write
    ifa.d_read = 1'b1; ifa.d_address = 32'h10;
    tick();
    chk1("dr_read", ifa.mem_read, 1'b1);
    chk1("dr_grant", gd_a, 1'b1);
    tick();
    tick();
    chk1("dr_done", ifa.d_done, 1'b1);
    chk32("dr_data", ifa.d_readdata, 32'h0000_BEEF);
    chk1("dr_i_done", ifa.i_done, 1'b0);
    ifa.d_read = 1'b0;
    tick();
    chk1("dr_done_once", ifa.d_done, 1'b0);
    chk32("dr_data_hold", ifa.d_readdata, 32'h0000_BEEF);

    // Asynchronous reset in the middle of a stalled read
    ifa.mem_waitrequest = 1'b1; ifa.i_read = 1'b1; ifa.i_address = 32'h300;
    tick();
    chk1("ar_read_before", ifa.mem_read, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("ar_read", ifa.mem_read, 1'b0);
    chk1("ar_busy", busy_a, 1'b0);
    chk1("ar_i_done", ifa.i_done, 1'b0);
    chk1("ar_d_done", ifa.d_done, 1'b0);
    chk32("ar_d_rdata", ifa.d_readdata, 32'h0);
    ifa.i_read = 1'b0; ifa.mem_waitrequest = 1'b0;
    #1 reset_n = 1'b1;
    ifa.i_read = 1'b1; ifa.i_address = 32'hBFC0_0000;
    tick();
    chk1("ar_f_c1", ifa.mem_read, 1'b1);
    tick();
    chk1("ar_f_c2", ifa.i_done, 1'b0);
    tick();
    chk1("ar_f_c3", ifa.i_done, 1'b1);
    chk32("ar_f_data", ifa.i_readdata, 32'h3C08_0001);
    ifa.i_read = 1'b0;
    tick();
    chk1("ar_f_c4", ifa.i_done, 1'b0);

    // Round-robin with both ports requesting continuously from a fresh reset
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    ifa.i_read = 1'b1; ifa.i_address = 32'h100;
    ifa.d_read = 1'b1; ifa.d_address = 32'h200;
    tick();
    chk32("rr1_addr", ifa.mem_address, 32'h100);
    chk1("rr1_grant", gd_a, 1'b0);
    tick();
    tick();
    chk1("rr1_i_done", ifa.i_done, 1'b1);
    chk1("rr1_d_done", ifa.d_done, 1'b0);
    chk32("rr1_data", ifa.i_readdata, 32'hA5A5_0100);
    tick();
    chk1("rr2_read", ifa.mem_read, 1'b1);
    chk32("rr2_addr", ifa.mem_address, 32'h200);
    chk1("rr2_grant", gd_a, 1'b1);
    chk1("rr2_i_done_off", ifa.i_done, 1'b0);
    tick();
    tick();
    chk1("rr2_d_done", ifa.d_done, 1'b1);
    chk1("rr2_i_done", ifa.i_done, 1'b0);
    chk32("rr2_data", ifa.d_readdata, 32'hA5A5_0200);
    tick();
    chk32("rr3_addr", ifa.mem_address, 32'h100);
    chk1("rr3_grant", gd_a, 1'b0);
    chk1("rr3_d_done_off", ifa.d_done, 1'b0);
    tick();
    tick();
    chk1("rr3_i_done", ifa.i_done, 1'b1);
    ifa.i_read = 1'b0; ifa.d_read = 1'b0;
    tick();
    chk1("rr_end_busy", busy_a, 1'b0);
    chk1("rr_end_read", ifa.mem_read, 1'b0);
    chk1("rr_end_i_done", ifa.i_done, 1'b0);

    // Data priority: tie goes to data, fetch follows once data drops
    ifb.i_read = 1'b1; ifb.i_address = 32'h400;
    ifb.d_read = 1'b1; ifb.d_address = 32'h500;
    tick();
    chk32("dp1_addr", ifb.mem_address, 32'h500);
    chk1("dp1_grant", gd_b, 1'b1);
    tick();
    tick();
    chk1("dp1_d_done", ifb.d_done, 1'b1);
    chk32("dp1_data", ifb.d_readdata, 32'hA5A5_0500);
    ifb.d_read = 1'b0;
    tick();
    chk32("dp2_addr", ifb.mem_address, 32'h400);
    chk1("dp2_grant", gd_b, 1'b0);
    tick();
    tick();
    chk1("dp2_i_done", ifb.i_done, 1'b1);
    chk32("dp2_data", ifb.i_readdata, 32'hA5A5_0400);
    ifb.i_read = 1'b0;
    tick();
    chk1("dp_end_busy", busy_b, 1'b0);
    chk1("dp_end_d_done", ifb.d_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
